// File: rtl/reg_writeback_unit.sv
// Writeback queue: merges memory-load and ALU results (memory has priority)
// into a small FIFO and drains one entry per cycle to the register file.
// pend_mask tracks which registers still have a write waiting in the queue.
module reg_writeback_unit #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_valid,
    input  logic [3:0]               mem_dest,
    input  logic [15:0]              mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [3:0]               alu_dest,
    input  logic [15:0]              alu_data,
    output logic                     alu_ready,
    input  logic                     wb_stall,
    output logic                     reg_write_en,
    output logic [3:0]               reg_write_dest,
    output logic [15:0]              reg_write_data,
    output logic [15:0]              pend_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Entry payload storage; occupancy is tracked separately in vld_q.
    logic [3:0]       dest_mem [DEPTH];
    logic [15:0]      data_mem [DEPTH];

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en_q, wr_en_d;
    logic [3:0]       wr_dest_q, wr_dest_d;
    logic [15:0]      wr_data_q, wr_data_d;

    logic             not_full;
    logic             take_mem;
    logic             take_alu;
    logic             push;
    logic             pop;
    logic [3:0]       in_dest;
    logic [15:0]      in_data;
    logic [15:0]      onehot [DEPTH];

    // Readiness depends only on occupancy, so a full queue refuses input even
    // while it drains; both readies are forced low while reset is asserted.
    assign not_full  = (count_q != CW'(DEPTH));
    assign mem_ready = rst_n & not_full;
    assign alu_ready = rst_n & not_full & ~mem_valid;

    assign take_mem  = mem_valid & mem_ready;
    assign take_alu  = alu_valid & alu_ready;
    assign in_dest   = take_mem ? mem_dest : alu_dest;
    assign in_data   = take_mem ? mem_data : alu_data;

    // Writes to register 0 are accepted but never enter the queue.
    assign push      = (take_mem | take_alu) & (in_dest != 4'd0);
    assign pop       = (count_q != '0) & ~wb_stall;

    // Next-state: tail push, head pop into the registered write port.
    always_comb begin
        vld_d     = vld_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_dest_d = wr_dest_q;
        wr_data_d = wr_data_q;
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
            wr_en_d         = 1'b1;
            wr_dest_d       = dest_mem[rd_ptr_q];
            wr_data_d       = data_mem[rd_ptr_q];
        end
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state with asynchronous clear; queued entries are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_dest_q <= 4'd0;
            wr_data_q <= 16'd0;
        end else begin
            vld_q     <= vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_dest_q <= wr_dest_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Payload write at the tail; contents are only meaningful where vld_q is set.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_mem[wr_ptr_q] <= in_dest;
            data_mem[wr_ptr_q] <= in_data;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
        assign onehot[gi] = vld_q[gi] ? (16'd1 << dest_mem[gi]) : 16'd0;
    end

    // Pending mask: union of destinations over occupied entries.
    always_comb begin
        pend_mask = 16'd0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_mask = pend_mask | onehot[i];
        end
    end

    assign reg_write_en   = wr_en_q;
    assign reg_write_dest = wr_dest_q;
    assign reg_write_data = wr_data_q;
    assign fifo_count     = count_q;

endmodule
